// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier with a carry-save reduction tree and valid/ready handshakes.
// Define BOOTH_MUL_OPCOUNT_EN to add the op_count output-handshake counter.
`timescale 1ns/1ps

module booth_mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [TAG_W-1:0]     out_tag
`ifdef BOOTH_MUL_OPCOUNT_EN
    ,
    output logic [31:0]          op_count
`endif
);

    localparam int P   = 2 * WIDTH;
    localparam int EXT = WIDTH + 2;
    localparam int NPP = WIDTH / 2 + 1;

    function automatic int csaLevels(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = (n / 3) * 2 + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = csaLevels(NPP);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_badWidth
            $error("booth_mul_pipe: WIDTH must be even and >= 4");
        end
    endgenerate

    logic               v1_q, v2_q, v3_q;
    logic               en1, en2, en3;
    logic [EXT-1:0]     aExt_q, bExt_q, aExt_d, bExt_d;
    logic [TAG_W-1:0]   tag1_q, tag2_q, tag3_q;
    logic [P-1:0]       sum_q, carry_q, sum_d, carry_d;
    logic [P-1:0]       prod_q, prod_d;

    logic [P-1:0]       aWide, a2Wide;
    logic [EXT:0]       bPad;
    logic [2:0]         grp;
    logic [P-1:0]       pp        [NPP];
    logic [P-1:0]       treeRows  [NPP];
    logic [P-1:0]       treeNext  [NPP];
    int                 treeN;

    // Each stage loads when empty or when its occupant moves on; in_ready never looks at in_valid.
    assign en3      = !v3_q || out_ready;
    assign en2      = !v2_q || en3;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    assign aExt_d = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
    assign bExt_d = {{2{in_signed & in_b[WIDTH-1]}}, in_b};

    always_comb begin
        aWide  = {{(P-EXT){aExt_q[EXT-1]}}, aExt_q};
        a2Wide = aWide << 1;
        bPad   = {bExt_q, 1'b0};
        grp    = '0;
        for (int i = 0; i < NPP; i++) begin
            pp[i] = '0;
        end
        for (int i = 0; i < NPP; i++) begin
            grp = bPad[2*i +: 3];
            case (grp)
                3'b001, 3'b010: pp[i] = aWide;
                3'b011:         pp[i] = a2Wide;
                3'b100:         pp[i] = -a2Wide;
                3'b101, 3'b110: pp[i] = -aWide;
                default:        pp[i] = '0;
            endcase
            pp[i] = pp[i] << (2 * i);
        end
    end

    // Wallace reduction: each level turns every full group of three rows into sum and carry rows.
    always_comb begin
        for (int k = 0; k < NPP; k++) begin
            treeNext[k] = '0;
            treeRows[k] = pp[k];
        end
        treeN = NPP;
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < NPP; k++) begin
                treeNext[k] = '0;
            end
            for (int g = 0; g < NPP / 3; g++) begin
                if (g < treeN / 3) begin
                    treeNext[2*g]   = treeRows[3*g] ^ treeRows[3*g+1] ^ treeRows[3*g+2];
                    treeNext[2*g+1] = ((treeRows[3*g]   & treeRows[3*g+1]) |
                                       (treeRows[3*g]   & treeRows[3*g+2]) |
                                       (treeRows[3*g+1] & treeRows[3*g+2])) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < treeN % 3) begin
                    treeNext[2*(treeN/3)+r] = treeRows[3*(treeN/3)+r];
                end
            end
            treeN = (treeN / 3) * 2 + treeN % 3;
            for (int k = 0; k < NPP; k++) begin
                treeRows[k] = treeNext[k];
            end
        end
        sum_d   = treeRows[0];
        carry_d = treeRows[1];
    end

    assign prod_d = sum_q + carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            aExt_q <= '0;
            bExt_q <= '0;
            tag1_q <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                aExt_q <= aExt_d;
                bExt_q <= bExt_d;
                tag1_q <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            tag2_q  <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                tag2_q  <= tag1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            prod_q <= '0;
            tag3_q <= '0;
        end else if (en3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                prod_q <= prod_d;
                tag3_q <= tag2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_prod  = prod_q;
    assign out_tag   = tag3_q;

`ifdef BOOTH_MUL_OPCOUNT_EN
    logic [31:0] opCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCount_q <= '0;
        end else if (v3_q && out_ready) begin
            opCount_q <= opCount_q + 32'd1;
        end
    end

    assign op_count = opCount_q;
`endif

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Self-checking bench for booth_mul_pipe: directed steps with a scoreboard of expected products.
// Exercises the op_count output as well when BOOTH_MUL_OPCOUNT_EN is defined.
`timescale 1ns/1ps

module tb_booth_mul_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                in_signed;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [2*WIDTH-1:0]  out_prod;
    logic [TAG_W-1:0]    out_tag;
`ifdef BOOTH_MUL_OPCOUNT_EN
    logic [31:0]         op_count;
`endif

    typedef struct packed {
        logic [63:0] prod;
        logic [3:0]  tag;
    } expEntry_t;

    expEntry_t sbQ[$];
    int        popCycles[$];
    int        cycleCount = 0;
    int        compared   = 0;
    int        mismatched = 0;

    booth_mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
`ifdef BOOTH_MUL_OPCOUNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // Scoreboard: a result is consumed at the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        expEntry_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_result_qsize", 64'(sbQ.size()), 64'd1);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("prod", out_prod, e.prod);
                    checkOutput("tag", {60'b0, out_tag}, {60'b0, e.tag});
                    popCycles.push_back(cycleCount);
                end
            end
            if (in_valid && in_ready) begin
                e.prod = refMul(in_a, in_b, in_signed);
                e.tag  = in_tag;
                sbQ.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] tag);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) checkOutput("accept_timeout", 64'(waited), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int w;
        w = 0;
        while (sbQ.size() != 0 && w < budget) begin
            @(posedge clk);
            w++;
        end
        #1;
        checkOutput("drain_qsize", 64'(sbQ.size()), 64'd0);
    endtask

    task automatic expectNext(input string name, input logic [63:0] expected);
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput(name, out_prod, expected);
    endtask

    initial begin
        int lat;
        int startPops;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("rst_out_prod", out_prod, 64'd0);
        checkOutput("rst_out_tag", {60'b0, out_tag}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("post_rst_out_valid", {63'b0, out_valid}, 64'd0);
`ifdef BOOTH_MUL_OPCOUNT_EN
        checkOutput("opcount_reset", {32'b0, op_count}, 64'd0);
`endif

        // Unsigned maximum and latency from the accept edge
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'd3);
        checkOutput("umax_prod", out_prod, 64'hFFFF_FFFE_0000_0001);
        waitDrain(20);

        // Signed corners
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h2);
        expectNext("neg1_sq", 64'h0000_0000_0000_0001);
        waitDrain(20);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 4'h3);
        expectNext("minint_sq", 64'h4000_0000_0000_0000);
        waitDrain(20);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 4'h4);
        expectNext("minint_x1", 64'hFFFF_FFFF_8000_0000);
        waitDrain(20);

        // Streaming: 8 back-to-back operations
        startPops = popCycles.size();
        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom, $urandom, 1'(i % 2), 4'(i));
        end
        waitDrain(50);
        checkOutput("stream_count", 64'(popCycles.size() - startPops), 64'd8);
        if (popCycles.size() >= startPops + 8) begin
            checkOutput("stream_consecutive", 64'(popCycles[startPops+7] - popCycles[startPops]), 64'd7);
        end

        // Backpressure: pipe fills after 3 accepts and holds its payload
        startPops = popCycles.size();
        out_ready = 1'b0;
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'h8);
        applyStimulus(32'hFFFF_FFF0, 32'h0000_0123, 1'b1, 4'h9);
        applyStimulus(32'h0000_0007, 32'h8000_0001, 1'b1, 4'hA);
        in_valid  = 1'b1;
        in_a      = 32'hDEAD_BEEF;
        in_b      = 32'h0000_0003;
        in_signed = 1'b0;
        in_tag    = 4'hB;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", {63'b0, in_ready}, 64'd0);
            checkOutput("bp_out_valid", {63'b0, out_valid}, 64'd1);
            checkOutput("bp_prod_hold", out_prod, sbQ[0].prod);
            checkOutput("bp_tag_hold", {60'b0, out_tag}, {60'b0, sbQ[0].tag});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {63'b0, in_ready}, 64'd1);
        applyStimulus(32'hDEAD_BEEF, 32'h0000_0003, 1'b0, 4'hB);
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 4'hC);
        applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 4'hD);
        waitDrain(50);
        checkOutput("bp_count", 64'(popCycles.size() - startPops), 64'd6);

        // Asynchronous reset with two operations in flight
        out_ready = 1'b0;
        applyStimulus(32'h0000_0011, 32'h0000_0022, 1'b0, 4'hE);
        applyStimulus(32'h0000_0033, 32'h0000_0044, 1'b0, 4'hF);
        @(posedge clk);
        #1;
        checkOutput("rst_pre_valid", {63'b0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("rst_async_prod", out_prod, 64'd0);
        sbQ.delete();
        startPops = popCycles.size();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_release_ready", {63'b0, in_ready}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_idle_valid", {63'b0, out_valid}, 64'd0);
        end
        checkOutput("rst_no_stale", 64'(popCycles.size() - startPops), 64'd0);

`ifdef BOOTH_MUL_OPCOUNT_EN
        // Output-handshake counter and its wrap
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'(i + 1), 32'(i + 2), 1'b0, 4'(i));
        end
        waitDrain(50);
        checkOutput("opcount_ten", {32'b0, op_count}, 64'd10);
        force dut.opCount_q = 32'hFFFF_FFFF;
        #1;
        release dut.opCount_q;
        applyStimulus(32'h0000_0005, 32'h0000_0006, 1'b0, 4'h1);
        waitDrain(20);
        checkOutput("opcount_wrap", {32'b0, op_count}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
